comp_rr_sched: RTL

// - Shares one W-bit magnitude comparator between NREQ requesters.
// - Uses round-robin arbitration and a valid/ready handshake on both the request and response sides.
// - Accepts one operand pair at a time and sequences it through a registered compare stage.
// - Holds the eq/lt/gt result until the requester's consumer takes it.
// - Sits between the requester blocks and the comparator datapath, so no block owns a private comparator.

---
 rtl/comp_pkg.sv | 20 ++
 rtl/mag_comp.sv | 25 ++
 rtl/comp_rr_sched.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/comp_pkg.sv
// ---------------------------------------------------------------------------
// comp_pkg
// Shared definitions for the round-robin comparator scheduler:
//   - state_t  : scheduler FSM encoding (2'd3 is unused and recovers to IDLE)
//   - RES_*    : bit positions inside the registered eq/lt/gt result vector
// ---------------------------------------------------------------------------
package comp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMP  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam int RES_EQ = 0;
   localparam int RES_LT = 1;
   localparam int RES_GT = 2;
   localparam int RES_W  = 3;

endpackage : comp_pkg

// File: rtl/mag_comp.sv
// ---------------------------------------------------------------------------
// mag_comp
// Purely combinational unsigned magnitude comparator. Exactly one of
// eq/lt/gt is high for any input pair (eq first, then gt, else lt).
// Ports:
//   a, b : W-bit unsigned operands
//   eq   : a == b
//   lt   : a <  b
//   gt   : a >  b
// ---------------------------------------------------------------------------
module mag_comp #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         eq,
   output logic         lt,
   output logic         gt
);

   assign eq = (a == b);
   assign gt = !eq && (a > b);
   assign lt = !eq && !gt;

endmodule : mag_comp

// File: rtl/comp_rr_sched.sv
// ---------------------------------------------------------------------------
// comp_rr_sched
// Shares one magnitude comparator between NREQ requesters. A round-robin
// arbiter accepts one operand pair in IDLE, the pair is compared from
// registers in CMP, and the result is held in RESP until the consumer
// takes it.
// Ports:
//   clk, rst          : rising-edge clock, asynchronous active-high reset
//   req_valid [NREQ]  : per-requester request valid
//   req_a/req_b       : packed operands, requester i at [i*W +: W]
//   req_ready [NREQ]  : one-hot grant, combinational in IDLE only
//   rsp_valid         : a result is held
//   rsp_ready         : consumer takes the result (honoured in RESP only)
//   rsp_id            : requester that owns the result
//   rsp_eq/lt/gt      : one-hot compare result
//   busy              : FSM is outside IDLE
// ---------------------------------------------------------------------------
module comp_rr_sched
   import comp_pkg::*;
#(
   parameter int W    = 4,
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic [NREQ-1:0]   req_ready,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic              rsp_eq,
   output logic              rsp_lt,
   output logic              rsp_gt,
   output logic              busy
);

   state_t           state_q, state_d;
   logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic [IDW-1:0]   id_q, id_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]   rsp_id_q, rsp_id_d;
   logic [RES_W-1:0] res_q, res_d;

   logic [NREQ-1:0]  grant_oh;
   logic [IDW-1:0]   grant_idx;
   logic             grant_any;
   logic             cmp_eq, cmp_lt, cmp_gt;

   // -----------------------------------------------------------------------
   // Round-robin search: first valid requester at or after rr_ptr, wrapping.
   // -----------------------------------------------------------------------
   always_comb begin
      int             sum;
      logic [IDW-1:0] cand;
      // NOTE: every combinational output gets a default before any branch;
      // a path that leaves a variable unassigned would infer a latch.
      grant_oh  = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      sum       = 0;
      cand      = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum = int'(rr_ptr_q) + k;
         if (sum >= NREQ) sum = sum - NREQ;
         cand = IDW'(sum);
         if (!grant_any && req_valid[cand]) begin
            grant_any      = 1'b1;
            grant_idx      = cand;
            grant_oh[cand] = 1'b1;
         end
      end
   end

   // Grants are offered only in IDLE; gating with rst keeps req_ready at 0
   // for the whole reset window even if requests are pending.
   assign req_ready = (state_q == ST_IDLE && !rst) ? grant_oh : '0;

   mag_comp #(.W(W)) u_mag_comp (
      .a  (a_q),
      .b  (b_q),
      .eq (cmp_eq),
      .lt (cmp_lt),
      .gt (cmp_gt)
   );

   // -----------------------------------------------------------------------
   // Next-state and datapath updates
   // -----------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      a_d         = a_q;
      b_d         = b_q;
      id_d        = id_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      res_d       = res_q;

      case (state_q)
         ST_IDLE: begin
            if (grant_any) begin
               a_d      = req_a[int'(grant_idx)*W +: W];
               b_d      = req_b[int'(grant_idx)*W +: W];
               id_d     = grant_idx;
               rr_ptr_d = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);
               state_d  = ST_CMP;
            end
         end
         ST_CMP: begin
            res_d[RES_EQ] = cmp_eq;
            res_d[RES_LT] = cmp_lt;
            res_d[RES_GT] = cmp_gt;
            rsp_id_d      = id_q;
            rsp_valid_d   = 1'b1;
            state_d       = ST_RESP;
         end
         ST_RESP: begin
            // Result fields are left untouched so they stay readable after
            // the handshake completes.
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            rsp_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         a_q         <= '0;
         b_q         <= '0;
         id_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         res_q       <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         a_q         <= a_d;
         b_q         <= b_d;
         id_q        <= id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         res_q       <= res_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_eq    = res_q[RES_EQ];
   assign rsp_lt    = res_q[RES_LT];
   assign rsp_gt    = res_q[RES_GT];
   assign busy      = (state_q != ST_IDLE);

endmodule : comp_rr_sched
